// File: rtl/init_pop.sv
// init_pop: fills a population register with xorshift32 words from a seed, then flags done
module init_pop #(
    parameter int          POP_WIDTH = 7501,
    parameter logic [31:0] SEED_SUB  = 32'hDEADBEEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [31:0]          prg_seed,
    output logic [POP_WIDTH-1:0] population,
    output logic                 done
);
    localparam int NWORDS = (POP_WIDTH + 31) / 32;
    localparam int IW = NWORDS > 1 ? $clog2(NWORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);

    logic          busy;
    logic [IW-1:0] idx;
    logic [31:0]   lfsr;
    logic [31:0]   x;
    logic          step;

    function automatic logic [31:0] xs(input logic [31:0] v);
        logic [31:0] a, b;
        a = v ^ (v << 13);
        b = a ^ (a >> 17);
        return b ^ (b << 5);
    endfunction

    assign x = xs(lfsr);
    assign step = busy && !start;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
            idx  <= '0;
            lfsr <= '0;
        end else if (start) begin
            lfsr <= (prg_seed != 32'd0) ? prg_seed : SEED_SUB;
            idx  <= '0;
            busy <= 1'b1;
            done <= 1'b0;
        end else if (busy) begin
            lfsr <= x;
            idx  <= (idx == LAST) ? '0 : idx + 1'b1;
            busy <= idx != LAST;
            done <= idx == LAST;
        end
    end

    // One register per word; the top word is only as wide as the bits left over
    for (genvar w = 0; w < NWORDS; w++) begin : g_word
        localparam int LO = 32 * w;
        localparam int WD = (POP_WIDTH - LO < 32) ? POP_WIDTH - LO : 32;
        logic [WD-1:0] word;
        always_ff @(posedge clk) begin
            if (!rst_n)
                word <= '0;
            else if (step && idx == IW'(w))
                word <= x[WD-1:0];
        end
        assign population[LO +: WD] = word;
    end
endmodule

// File: tb/tb_init_pop.sv
// tb_init_pop: randomized scoreboard bench for init_pop against an arithmetic xorshift model
module tb_init_pop;
    localparam int P = 7501;
    localparam int NW = (P + 31) / 32;
    localparam logic [31:0] SUB = 32'hDEADBEEF;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [31:0]  prg_seed = 32'd0;
    logic [P-1:0] population;
    logic         done;

    int errors = 0;
    int checks = 0;
    logic [P-1:0] exp_q[$];
    logic [P-1:0] snap;
    logic         prev_done = 1'b0;

    init_pop #(.POP_WIDTH(P), .SEED_SUB(SUB)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .prg_seed(prg_seed),
        .population(population), .done(done)
    );

    always #5 clk = ~clk;

    // xorshift32 written as modular multiply/divide by powers of two
    function automatic logic [31:0] xs_m(input logic [31:0] v);
        logic [31:0] r;
        r = v ^ (v * 32'd8192);
        r = r ^ (r / 32'd131072);
        r = r ^ (r * 32'd32);
        return r;
    endfunction

    function automatic logic [P-1:0] model_pop(input logic [31:0] seed);
        logic [P-1:0] r;
        logic [31:0]  v;
        r = '0;
        v = (seed == 32'd0) ? SUB : seed;
        for (int k = 0; k < NW; k++) begin
            v = xs_m(v);
            for (int b = 0; b < 32; b++)
                if (32 * k + b < P) r[32 * k + b] = v[b];
        end
        return r;
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] seed, input int k);
        logic [31:0] v;
        v = (seed == 32'd0) ? SUB : seed;
        for (int i = 0; i <= k; i++) v = xs_m(v);
        return v;
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_pop(input string name, input logic [P-1:0] act, input logic [P-1:0] exp);
        int k;
        checks++;
        if (act !== exp) begin
            errors++;
            k = 0;
            while (k < NW - 1 && act[32 * k +: 32] === exp[32 * k +: 32]) k++;
            $display("FAIL %s: word %0d got %h expected %h", name, k,
                     act[32 * k +: 32], exp[32 * k +: 32]);
        end
    endtask

    // Monitor: every rising done must match the pending run's expected population
    always @(negedge clk) begin
        if (done && !prev_done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no completion");
            end else begin
                chk_pop("run_result", population, exp_q.pop_front());
            end
        end
        prev_done = done;
    end

    task automatic start_run(input logic [31:0] seed);
        @(negedge clk);
        exp_q.delete();
        exp_q.push_back(model_pop(seed));
        start = 1'b1;
        prg_seed = seed;
        @(negedge clk);
        start = 1'b0;
        prg_seed = $urandom;
    endtask

    task automatic wait_run(input logic [31:0] seed);
        int c;
        c = 0;
        while (c < 400) begin
            @(negedge clk);
            c++;
            if (c == 1) chk32("word0", population[31:0], model_word(seed, 0));
            if (done) break;
        end
        chk32("done_latency", 32'(c), 32'(NW));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk_pop("reset_pop", population, '0);
        chk32("reset_done", 32'(done), 32'd0);
        repeat (5) @(negedge clk);
        chk_pop("idle_pop", population, '0);
        chk32("idle_done", 32'(done), 32'd0);

        start_run(32'd1);
        wait_run(32'd1);
        chk32("seed1_word0", population[31:0], 32'h00042021);
        chk32("last_word", 32'(population[P-1:32*(NW-1)]), model_word(32'd1, NW - 1) & 32'h1FFF);
        snap = population;
        repeat (10) @(negedge clk);
        chk_pop("idle_hold", population, snap);
        chk32("done_level", 32'(done), 32'd1);

        start_run(32'd0);
        wait_run(32'd0);
        snap = population;
        start_run(SUB);
        wait_run(SUB);
        chk_pop("seed0_equiv", population, snap);

        start_run(32'd12345);
        wait_run(32'd12345);
        snap = population;
        repeat (17) @(negedge clk);
        start_run(32'd12345);
        wait_run(32'd12345);
        chk_pop("repeat_seed", population, snap);

        start_run(32'd1);
        repeat (99) @(negedge clk);
        chk32("restart_busy_done", 32'(done), 32'd0);
        start_run(32'd2);
        wait_run(32'd2);
        chk_pop("restart_result", population, model_pop(32'd2));

        start_run(32'd12345);
        repeat (49) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk_pop("abort_pop", population, '0);
        chk32("abort_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk_pop("abort_quiet_pop", population, '0);
        chk32("abort_quiet_done", 32'(done), 32'd0);

        for (int i = 0; i < 3; i++) begin
            logic [31:0] s;
            s = $urandom;
            start_run(s);
            wait_run(s);
        end

        repeat (3) @(negedge clk);
        chk32("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
